instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//   Instruction fetch stage: owns the program counter, issues read requests to the
//   instruction ROM (registered output, 1-cycle read latency) and delivers each fetched
//   word to the decoder over a valid/ready handshake. Sits between the ROM and decode;
//   the execute stage steers it via redirect (branch/jump) and halt.
// PARAMETERS
//   ADDR_W    16       width of pc, rom_addr, instr_pc, redirect_pc
//   DATA_W    16       instruction word width
//   MEM_DEPTH 512      ROM depth in words; power of two; pc wraps modulo MEM_DEPTH
//   RESET_PC  16'h0000 pc value after reset (must be < MEM_DEPTH)
// PORTS
//   clk          in   1       system clock; ROM is clocked on the same clk
//   rst_n        in   1       synchronous reset, active low
//   rom_addr     out  ADDR_W  ROM read address (= pc)
//   rom_en       out  1       ROM read enable; ROM returns mem[rom_addr] on rom_q after the edge
//   rom_q        in   DATA_W  ROM read data, valid in the cycle after rom_en was sampled
//   instr        out  DATA_W  fetched instruction word
//   instr_pc     out  ADDR_W  address instr was fetched from
//   instr_valid  out  1       instr/instr_pc valid
//   instr_ready  in   1       decoder accepts; transfer = instr_valid & instr_ready at an edge
//   redirect     in   1       load redirect_pc into pc, flush the in-flight fetch
//   redirect_pc  in   ADDR_W  new pc, taken modulo MEM_DEPTH
//   halt         in   1       level; stop issuing new fetches
// BEHAVIOUR
// - Synchronous reset (rst_n=0 at an edge), overriding all other inputs:
//   state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0.
//   rom_en=0 and rom_addr=RESET_PC from that edge on.
// - rom_addr=pc and rom_en=(state==FETCH), decoded from registers only; no input->output paths.
// - FSM, one request outstanding at most:
//   IDLE : rom_en=0. halt=0 -> FETCH, else stay.
//   FETCH: rom_en=1. halt=1 -> IDLE (no request counted); otherwise -> WAIT.
//   WAIT : rom_en=0. At the edge: instr<=rom_q, instr_pc<=pc, instr_valid<=1,
//          pc<=(pc+1)%MEM_DEPTH -> VALID.
//   VALID: instr/instr_pc held stable while instr_valid=1 and instr_ready=0.
//          On transfer: instr_valid<=0; -> FETCH if halt=0, else IDLE.
// - Throughput: 1 instruction per 3 cycles with instr_ready tied high.
//   Latency: rom_en high at edge k -> instr_valid high after edge k+1.
// - Redirect (any state, priority over ready and halt): pc<=redirect_pc%MEM_DEPTH,
//   instr_valid<=0. The word held in VALID is dropped even if instr_ready=1 in the same
//   cycle; it is not transferred. A rom_q pending in WAIT is discarded.
//   Next state is FETCH if halt=0, else IDLE.
// - Halt never aborts WAIT or VALID: the in-flight word is still delivered.
// - Wrap: pc=MEM_DEPTH-1 increments to 0. Upper ADDR_W bits above log2(MEM_DEPTH) are always 0.
// - Reset mid-operation: any in-flight ROM data is ignored and the pipe restarts from RESET_PC.
// TESTING
// - ROM[0]=16'h1234, ROM[1]=16'hABCD; rst_n=0 for 2 cycles, halt=0, ready=1 -> rom_en at
//   addr 0, then instr=1234/pc=0; 3 cycles later instr=ABCD/pc=1; rom_en=0 during reset.
// - ready=0 for 5 cycles while valid -> instr=1234, pc=0 held, rom_en=0, no new request;
//   ready=1 -> one transfer, next rom_addr=1.
// - redirect=1, redirect_pc=16'h0040 in WAIT -> fetched word never appears;
//   next rom_addr=0x0040, next instr_pc=0x0040.
// - redirect in VALID with ready=1 the same cycle -> no transfer counted by the scoreboard;
//   the next word comes from the new pc.
// - redirect_pc=16'h01FF (also 16'h03FF) -> instr_pc 0x01FF, then 0x0000.
// - halt=1 during VALID -> word still transfers, then rom_en stays 0 (IDLE);
//   halt=0 -> resumes at pc+1.
// - rst_n=0 during WAIT -> instr_valid=0 after the edge, no stale word,
//   first fetch after release at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: pc, ROM requests, valid/ready delivery to decode
module instr_fetch #(
   parameter int                 ADDR_W    = 16,
   parameter int                 DATA_W    = 16,
   parameter int                 MEM_DEPTH = 512,
   parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_en,
   input  logic [DATA_W-1:0] rom_q,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              halt
);

   // Masking with MEM_DEPTH-1 gives the modulo wrap because MEM_DEPTH is a power of two.
   localparam logic [ADDR_W-1:0] PC_MASK = ADDR_W'(MEM_DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      VALID = 2'd3
   } state_t;

   state_t            state;
   state_t            state_n;
   logic [ADDR_W-1:0] pc;

   // Outputs to the ROM come straight from registers so no input reaches them combinationally.
   assign rom_addr = pc;
   assign rom_en   = (state == FETCH);

   // Next-state decode; redirect outranks ready and halt in every state.
   always_comb begin
      state_n = state;
      if (redirect) begin
         state_n = halt ? IDLE : FETCH;
      end else begin
         case (state)
            IDLE:    if (!halt) state_n = FETCH;
            FETCH:   state_n = halt ? IDLE : WAIT;
            WAIT:    state_n = VALID;
            VALID:   if (instr_ready) state_n = halt ? IDLE : FETCH;
            default: state_n = IDLE;
         endcase
      end
   end

   // State, pc and the delivered word; a redirect suppresses the WAIT capture so the pending word is lost.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         pc          <= RESET_PC & PC_MASK;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
      end else begin
         state <= state_n;
         if (redirect) begin
            pc          <= redirect_pc & PC_MASK;
            instr_valid <= 1'b0;
         end else if (state == WAIT) begin
            instr       <= rom_q;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= (pc + ADDR_W'(1)) & PC_MASK;
         end else if (state == VALID && instr_ready) begin
            instr_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed vector bench for instr_fetch with a registered ROM model
module tb_instr_fetch;

   logic        clk;
   logic        rst_n;
   logic [15:0] rom_addr;
   logic        rom_en;
   logic [15:0] rom_q;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        halt;

   instr_fetch #(
      .ADDR_W(16), .DATA_W(16), .MEM_DEPTH(512), .RESET_PC(16'h0000)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .rom_addr(rom_addr), .rom_en(rom_en), .rom_q(rom_q),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .redirect(redirect),
      .redirect_pc(redirect_pc), .halt(halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM contents: 0 -> 1234, 1 -> ABCD, others -> C000 + address
   logic [15:0] rom [512];
   initial begin
      for (int i = 0; i < 512; i++) rom[i] = 16'hC000 + 16'(i);
      rom[0] = 16'h1234;
      rom[1] = 16'hABCD;
      rom_q  = 16'h0000;
   end

   // Registered-output ROM with one cycle of read latency
   always @(posedge clk) begin
      if (rom_en) rom_q <= rom[rom_addr[8:0]];
   end

   typedef struct {
      logic        rst_n, halt, rdy, redir;
      logic [15:0] rpc;
      logic        en;
      logic [15:0] addr;
      logic        v;
      logic [15:0] ins, ipc;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic add(input logic r, input logic h, input logic rd, input logic rdir,
                      input logic [15:0] rpc, input logic en, input logic [15:0] addr,
                      input logic v, input logic [15:0] ins, input logic [15:0] ipc);
      vec_t e;
      e.rst_n = r; e.halt = h; e.rdy = rd; e.redir = rdir; e.rpc = rpc;
      e.en = en; e.addr = addr; e.v = v; e.ins = ins; e.ipc = ipc;
      tbl.push_back(e);
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      int cyc;
      int last_cyc;
      int t;

      rst_n = 1'b0; halt = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 16'h0;

      //   rst h  rdy rdr rpc        en addr      v  instr      ipc
      // reset for two cycles
      add(0, 0, 1, 0, 16'h0000,   0, 16'h0000, 0, 16'h0000, 16'h0000);
      add(0, 0, 1, 0, 16'h0000,   0, 16'h0000, 0, 16'h0000, 16'h0000);
      // first fetch at address 0, decoder stalls five cycles
      add(1, 0, 1, 0, 16'h0000,   1, 16'h0000, 0, 16'h0000, 16'h0000);
      add(1, 0, 1, 0, 16'h0000,   0, 16'h0000, 0, 16'h0000, 16'h0000);
      add(1, 0, 0, 0, 16'h0000,   0, 16'h0001, 1, 16'h1234, 16'h0000);
      for (int i = 0; i < 5; i++)
         add(1, 0, 0, 0, 16'h0000, 0, 16'h0001, 1, 16'h1234, 16'h0000);
      add(1, 0, 1, 0, 16'h0000,   1, 16'h0001, 0, 16'h1234, 16'h0000);
      add(1, 0, 1, 0, 16'h0000,   0, 16'h0001, 0, 16'h1234, 16'h0000);
      add(1, 0, 1, 0, 16'h0000,   0, 16'h0002, 1, 16'hABCD, 16'h0001);
      add(1, 0, 1, 0, 16'h0000,   1, 16'h0002, 0, 16'hABCD, 16'h0001);
      add(1, 0, 1, 0, 16'h0000,   0, 16'h0002, 0, 16'hABCD, 16'h0001);
      // redirect to 0x0040 while in WAIT: word C002 is discarded
      add(1, 0, 1, 1, 16'h0040,   1, 16'h0040, 0, 16'hABCD, 16'h0001);
      add(1, 0, 1, 0, 16'h0000,   0, 16'h0040, 0, 16'hABCD, 16'h0001);
      add(1, 0, 1, 0, 16'h0000,   0, 16'h0041, 1, 16'hC040, 16'h0040);
      // redirect to 0x01FF in VALID with ready=1: no transfer, then wrap to 0
      add(1, 0, 1, 1, 16'h01FF,   1, 16'h01FF, 0, 16'hC040, 16'h0040);
      add(1, 0, 1, 0, 16'h0000,   0, 16'h01FF, 0, 16'hC040, 16'h0040);
      add(1, 0, 1, 0, 16'h0000,   0, 16'h0000, 1, 16'hC1FF, 16'h01FF);
      add(1, 0, 1, 0, 16'h0000,   1, 16'h0000, 0, 16'hC1FF, 16'h01FF);
      add(1, 0, 1, 0, 16'h0000,   0, 16'h0000, 0, 16'hC1FF, 16'h01FF);
      add(1, 0, 1, 0, 16'h0000,   0, 16'h0001, 1, 16'h1234, 16'h0000);
      // redirect to 0x03FF folds to 0x01FF; halt asserted in WAIT does not abort it
      add(1, 0, 1, 1, 16'h03FF,   1, 16'h01FF, 0, 16'h1234, 16'h0000);
      add(1, 0, 1, 0, 16'h0000,   0, 16'h01FF, 0, 16'h1234, 16'h0000);
      add(1, 1, 1, 0, 16'h0000,   0, 16'h0000, 1, 16'hC1FF, 16'h01FF);
      // halt in VALID: word transfers, then IDLE with rom_en low
      add(1, 1, 1, 0, 16'h0000,   0, 16'h0000, 0, 16'hC1FF, 16'h01FF);
      add(1, 1, 1, 0, 16'h0000,   0, 16'h0000, 0, 16'hC1FF, 16'h01FF);
      add(1, 1, 1, 0, 16'h0000,   0, 16'h0000, 0, 16'hC1FF, 16'h01FF);
      add(1, 0, 1, 0, 16'h0000,   1, 16'h0000, 0, 16'hC1FF, 16'h01FF);
      add(1, 0, 1, 0, 16'h0000,   0, 16'h0000, 0, 16'hC1FF, 16'h01FF);
      add(1, 0, 1, 0, 16'h0000,   0, 16'h0001, 1, 16'h1234, 16'h0000);
      add(1, 0, 1, 0, 16'h0000,   1, 16'h0001, 0, 16'h1234, 16'h0000);
      add(1, 0, 1, 0, 16'h0000,   0, 16'h0001, 0, 16'h1234, 16'h0000);
      // reset while in WAIT: pending ABCD is dropped, restart from 0
      add(0, 0, 1, 0, 16'h0000,   0, 16'h0000, 0, 16'h0000, 16'h0000);
      add(1, 0, 1, 0, 16'h0000,   1, 16'h0000, 0, 16'h0000, 16'h0000);
      add(1, 0, 1, 0, 16'h0000,   0, 16'h0000, 0, 16'h0000, 16'h0000);
      add(1, 0, 1, 0, 16'h0000,   0, 16'h0001, 1, 16'h1234, 16'h0000);
      // halt in FETCH cancels the request
      add(1, 0, 1, 0, 16'h0000,   1, 16'h0001, 0, 16'h1234, 16'h0000);
      add(1, 1, 1, 0, 16'h0000,   0, 16'h0001, 0, 16'h1234, 16'h0000);
      add(1, 0, 1, 0, 16'h0000,   1, 16'h0001, 0, 16'h1234, 16'h0000);
      add(1, 0, 1, 0, 16'h0000,   0, 16'h0001, 0, 16'h1234, 16'h0000);
      add(1, 0, 1, 0, 16'h0000,   0, 16'h0002, 1, 16'hABCD, 16'h0001);
      // redirect while halted in IDLE loads pc but issues nothing until halt drops
      add(1, 1, 1, 0, 16'h0000,   0, 16'h0002, 0, 16'hABCD, 16'h0001);
      add(1, 1, 1, 1, 16'h0010,   0, 16'h0010, 0, 16'hABCD, 16'h0001);
      add(1, 0, 1, 0, 16'h0000,   1, 16'h0010, 0, 16'hABCD, 16'h0001);

      foreach (tbl[i]) begin
         @(negedge clk);
         rst_n       = tbl[i].rst_n;
         halt        = tbl[i].halt;
         instr_ready = tbl[i].rdy;
         redirect    = tbl[i].redir;
         redirect_pc = tbl[i].rpc;
         @(posedge clk);
         #1;
         check($sformatf("row%0d rom_en", i),      16'(rom_en),      16'(tbl[i].en));
         check($sformatf("row%0d rom_addr", i),    rom_addr,         tbl[i].addr);
         check($sformatf("row%0d instr_valid", i), 16'(instr_valid), 16'(tbl[i].v));
         check($sformatf("row%0d instr", i),       instr,            tbl[i].ins);
         check($sformatf("row%0d instr_pc", i),    instr_pc,         tbl[i].ipc);
      end

      // Free run with ready tied high: one word every 3 cycles from 0x0010 onward
      @(negedge clk);
      halt = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 16'h0;
      cyc = 0;
      last_cyc = 0;
      for (int w = 0; w < 4; w++) begin
         t = 0;
         do begin
            @(posedge clk);
            #1;
            cyc++;
            t++;
         end while (!instr_valid && t < 10);
         if (!instr_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL run word%0d timeout: got no valid within 10 cycles, expected valid", w);
         end else begin
            check($sformatf("run word%0d instr_pc", w), instr_pc, 16'h0010 + 16'(w));
            check($sformatf("run word%0d instr", w),    instr,    16'hC010 + 16'(w));
            if (w > 0)
               check($sformatf("run word%0d spacing", w), 16'(cyc - last_cyc), 16'd3);
            last_cyc = cyc;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
